// File: rtl/ram_read_arbiter.sv
// ram_read_arbiter
// Shares the single ram_logic read stream (ready/valid PCM samples) between
// N_CONS consumers. Each grant covers one whole buffer of BURST_LEN samples
// and grants rotate round-robin. Data is a combinational pass-through; only
// the handshake is steered to the granted consumer.
//
// Optional feature: define RAM_ARB_WDOG_EN to add a stall watchdog. After
// WDOG_CYCLES consecutive transfer cycles without a beat, err_o latches and
// the rest of the buffer is drained (and discarded) so ram_logic is never
// left holding a half-read buffer.
//
// Ports:
//   clk_i, rst_ni      clock, synchronous active-low reset
//   buf_ready_i        ram_logic has a full buffer
//   ram_data_i/valid_i ram_logic read stream; ram_ready_o back to ram_logic
//   req_i              per-consumer level request
//   cons_data_o        sample broadcast to all consumers
//   cons_valid_o       one-hot valid, only on the granted consumer
//   cons_ready_i       per-consumer ready (ignored unless granted)
//   grant_o            registered one-hot grant
//   busy_o             arbitration/transfer in progress
//   burst_done_o       one-cycle pulse after the last beat of a burst
//   err_o              sticky watchdog error (0 without RAM_ARB_WDOG_EN)
module ram_read_arbiter #(
  parameter int N_CONS      = 2,
  parameter int DATA_W      = 24,
  parameter int BURST_LEN   = 256,
  parameter int WDOG_CYCLES = 4096
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              buf_ready_i,
  input  logic [DATA_W-1:0] ram_data_i,
  input  logic              ram_valid_i,
  output logic              ram_ready_o,
  input  logic [N_CONS-1:0] req_i,
  output logic [DATA_W-1:0] cons_data_o,
  output logic [N_CONS-1:0] cons_valid_o,
  input  logic [N_CONS-1:0] cons_ready_i,
  output logic [N_CONS-1:0] grant_o,
  output logic              busy_o,
  output logic              burst_done_o,
  output logic              err_o
);

  localparam int IDX_W = (N_CONS > 1) ? $clog2(N_CONS) : 1;
  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_CONS - 1);

`ifdef RAM_ARB_WDOG_EN
  typedef enum logic [2:0] {IDLE, ARB, XFER, DONE, DRAIN} state_t;
`else
  typedef enum logic [1:0] {IDLE, ARB, XFER, DONE} state_t;
`endif

  state_t            state, state_nxt;
  logic [N_CONS-1:0] grant;
  logic [IDX_W-1:0]  gnt_idx;
  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  sel_idx;
  logic [IDX_W-1:0]  cand;
  logic              sel_found;
  logic [CNT_W-1:0]  beat_cnt;
  logic              beat;

  assign cons_data_o = ram_data_i;
  assign grant_o     = grant;

  // Round-robin pick: scan from the highest offset down so the last hit
  // written is the nearest requester at or after the pointer.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = N_CONS - 1; k >= 0; k--) begin
      cand = IDX_W'((int'(ptr) + k) % N_CONS);
      if (req_i[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

`ifdef RAM_ARB_WDOG_EN
  localparam int STALL_W = $clog2(WDOG_CYCLES + 1);
  logic [STALL_W-1:0] stall_cnt;
  logic               stall_lim;
  logic               err;

  assign stall_lim = (stall_cnt == STALL_W'(WDOG_CYCLES - 1));
  assign err_o     = err;
`else
  assign err_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    ram_ready_o  = 1'b0;
    cons_valid_o = '0;
    busy_o       = 1'b0;
    burst_done_o = 1'b0;
    beat         = 1'b0;
    case (state)
      IDLE: begin
        // With no requester the buffer stays parked in RAM (ready held low).
        if (buf_ready_i && (|req_i)) state_nxt = ARB;
      end
      ARB: begin
        busy_o    = 1'b1;
        state_nxt = sel_found ? XFER : IDLE;
      end
      XFER: begin
        busy_o       = 1'b1;
        ram_ready_o  = |(cons_ready_i & grant);
        cons_valid_o = grant & {N_CONS{ram_valid_i}};
        beat         = ram_valid_i && ram_ready_o;
        if (beat && (beat_cnt == LAST_BEAT)) state_nxt = DONE;
`ifdef RAM_ARB_WDOG_EN
        else if (!beat && stall_lim) state_nxt = DRAIN;
`endif
      end
`ifdef RAM_ARB_WDOG_EN
      DRAIN: begin
        // Stalled consumer is cut off; finish the buffer and drop the data.
        busy_o      = 1'b1;
        ram_ready_o = 1'b1;
        beat        = ram_valid_i;
        if (beat && (beat_cnt == LAST_BEAT)) state_nxt = DONE;
      end
`endif
      DONE: begin
        burst_done_o = 1'b1;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Grant, beat counter and round-robin pointer. The grant is held for the
  // whole burst regardless of req_i so ram_logic always drains a full buffer.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      grant    <= '0;
      gnt_idx  <= '0;
      ptr      <= '0;
      beat_cnt <= '0;
    end else begin
      if (state == ARB) begin
        beat_cnt <= '0;
        if (sel_found) begin
          grant   <= N_CONS'(1) << sel_idx;
          gnt_idx <= sel_idx;
        end
      end else if (beat) begin
        beat_cnt <= beat_cnt + CNT_W'(1);
      end
      if (state_nxt == DONE) grant <= '0;
      if (state == DONE) ptr <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + IDX_W'(1);
    end
  end

`ifdef RAM_ARB_WDOG_EN
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stall_cnt <= '0;
      err       <= 1'b0;
    end else begin
      if ((state == ARB) || beat) stall_cnt <= '0;
      else if (state == XFER)     stall_cnt <= stall_cnt + STALL_W'(1);
      if ((state == XFER) && (state_nxt == DRAIN)) err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ram_read_arbiter.sv
// Testbench for ram_read_arbiter: a cycle-level reference model derived from
// the arbitration rules is compared against the DUT every cycle, and directed
// scenarios pin the model with hand-computed values.
`timescale 1ns/1ps
module tb_ram_read_arbiter;
  localparam int NC = 2;
  localparam int DW = 24;
  localparam int BL = 256;
  localparam int WD = 16;
  localparam int M_IDLE = 0, M_ARB = 1, M_XFER = 2, M_DONE = 3, M_DRAIN = 4;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          buf_ready_i = 1'b0;
  logic [DW-1:0] ram_data_i = '0;
  logic          ram_valid_i = 1'b0;
  logic          ram_ready_o;
  logic [NC-1:0] req_i = '0;
  logic [DW-1:0] cons_data_o;
  logic [NC-1:0] cons_valid_o;
  logic [NC-1:0] cons_ready_i = '0;
  logic [NC-1:0] grant_o;
  logic          busy_o;
  logic          burst_done_o;
  logic          err_o;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int vmode    = 0;   // 0: ram_valid always 1, 1: valid 3 of 4 cycles
  int crmode   = 0;   // 0: all ready, 1: toggle 50%, 2: use cr_hold
  logic [NC-1:0] cr_hold = '0;
  int cyc = 0;
  logic [DW-1:0] word = '0;

  ram_read_arbiter #(
    .N_CONS(NC), .DATA_W(DW), .BURST_LEN(BL), .WDOG_CYCLES(WD)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .buf_ready_i(buf_ready_i),
    .ram_data_i(ram_data_i), .ram_valid_i(ram_valid_i), .ram_ready_o(ram_ready_o),
    .req_i(req_i), .cons_data_o(cons_data_o), .cons_valid_o(cons_valid_o),
    .cons_ready_i(cons_ready_i), .grant_o(grant_o), .busy_o(busy_o),
    .burst_done_o(burst_done_o), .err_o(err_o)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void fail_now(string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endfunction

  // ram_logic stand-in: incrementing sample advances on each handshake.
  initial begin
    logic hs;
    forever begin
      @(negedge clk);
      hs = ram_valid_i && ram_ready_o;
      @(posedge clk);
      #1;
      cyc++;
      if (hs) word = word + DW'(1);
      ram_data_i  = word;
      ram_valid_i = (vmode == 0) ? 1'b1 : ((cyc % 4) != 3);
      case (crmode)
        0:       cons_ready_i = '1;
        1:       cons_ready_i = ((cyc % 2) == 1) ? '1 : '0;
        default: cons_ready_i = cr_hold;
      endcase
    end
  end

  // Reference model: phase, owner, beats taken, stall run, rotation pointer.
  initial begin
    int ph, owner, ptr, beats, stall, c;
    bit err, found;
    logic [NC-1:0] e_grant, e_valid;
    logic e_ready, e_busy, e_done;
    ph = M_IDLE; owner = 0; ptr = 0; beats = 0; stall = 0; err = 0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      e_grant = (ph == M_XFER || ph == M_DRAIN) ? (NC'(1) << owner) : '0;
      e_ready = (ph == M_XFER) ? cons_ready_i[owner] : (ph == M_DRAIN);
      e_valid = (ph == M_XFER && ram_valid_i) ? e_grant : '0;
      e_busy  = (ph == M_ARB || ph == M_XFER || ph == M_DRAIN);
      e_done  = (ph == M_DONE);
      check("m_grant", 32'(grant_o), 32'(e_grant));
      check("m_cons_valid", 32'(cons_valid_o), 32'(e_valid));
      check("m_ram_ready", 32'(ram_ready_o), 32'(e_ready));
      check("m_busy", 32'(busy_o), 32'(e_busy));
      check("m_burst_done", 32'(burst_done_o), 32'(e_done));
      check("m_data", 32'(cons_data_o), 32'(ram_data_i));
      check("m_err", 32'(err_o), 32'(err));
      if (!rst_ni) begin
        ph = M_IDLE; owner = 0; ptr = 0; beats = 0; stall = 0; err = 0;
      end else begin
        case (ph)
          M_IDLE: if (buf_ready_i && (req_i != '0)) ph = M_ARB;
          M_ARB: begin
            if (req_i == '0) ph = M_IDLE;
            else begin
              found = 0;
              for (int k = 0; k < NC; k++) begin
                c = (ptr + k) % NC;
                if (!found && req_i[c]) begin owner = c; found = 1; end
              end
              beats = 0; stall = 0; ph = M_XFER;
            end
          end
          M_XFER: begin
            if (ram_valid_i && cons_ready_i[owner]) begin
              beats++; stall = 0;
              if (beats == BL) ph = M_DONE;
            end else begin
              stall++;
`ifdef RAM_ARB_WDOG_EN
              if (stall == WD) begin err = 1; ph = M_DRAIN; end
`endif
            end
          end
          M_DRAIN: if (ram_valid_i) begin
            beats++;
            if (beats == BL) ph = M_DONE;
          end
          default: begin ptr = (owner + 1) % NC; ph = M_IDLE; end
        endcase
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst_ni = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_ni = 1'b1;
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_grant"}, 32'(grant_o), 32'd0);
    check({tag, "_busy"}, 32'(busy_o), 32'd0);
    check({tag, "_done"}, 32'(burst_done_o), 32'd0);
    check({tag, "_ram_ready"}, 32'(ram_ready_o), 32'd0);
    check({tag, "_cons_valid"}, 32'(cons_valid_o), 32'd0);
    check({tag, "_err"}, 32'(err_o), 32'd0);
  endtask

  // Waits for a grant, then counts beats until burst_done_o (or stop_at beats).
  // Returns at the negedge of the DONE cycle (or of the stop_at-th beat).
  task automatic run_burst(input string tag, output logic [NC-1:0] g,
                           output int nb0, output int nb1, output int nh,
                           output int oerr, input int stop_at);
    int t;
    logic [DW-1:0] prev;
    bit have_prev;
    g = '0; nb0 = 0; nb1 = 0; nh = 0; oerr = 0; have_prev = 0; prev = '0; t = 0;
    @(negedge clk);
    while (grant_o == '0 && t < 64) begin @(negedge clk); t++; end
    if (grant_o == '0) begin fail_now({tag, "_grant_wait"}); return; end
    g = grant_o;
    t = 0;
    while (t < 8 * BL) begin
      if (ram_valid_i && ram_ready_o) nh++;
      if (cons_valid_o[0] && cons_ready_i[0]) nb0++;
      if (cons_valid_o[1] && cons_ready_i[1]) nb1++;
      if ((cons_valid_o & cons_ready_i) != '0) begin
        if (have_prev && cons_data_o != prev + DW'(1)) oerr++;
        prev = cons_data_o;
        have_prev = 1;
      end
      if (burst_done_o) break;
      if (stop_at > 0 && (nb0 + nb1) >= stop_at) break;
      @(negedge clk);
      t++;
    end
    if (t >= 8 * BL) fail_now({tag, "_burst_wait"});
  endtask

  initial begin
    logic [NC-1:0] g;
    logic [NC-1:0] exp_seq [4];
    int nb0, nb1, nh, oerr, n, t, nd;
    exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01; exp_seq[3] = 2'b10;

    // 1: reset with requests pending, first grant, one full burst
    buf_ready_i = 1'b1; req_i = 2'b11; crmode = 0; vmode = 0;
    repeat (4) @(posedge clk);
    #1;
    check_all_zero("t1_reset");
    rst_ni = 1'b1;
    @(posedge clk); #1;
    check("t1_arb_grant", 32'(grant_o), 32'd0);
    check("t1_arb_busy", 32'(busy_o), 32'd1);
    @(posedge clk); #1;
    check("t1_first_grant", 32'(grant_o), 32'd1);
    run_burst("t1", g, nb0, nb1, nh, oerr, 0);
    check("t1_beats0", 32'(nb0), 32'(BL));
    check("t1_beats1", 32'(nb1), 32'd0);
    check("t1_done_here", 32'(burst_done_o), 32'd1);
    @(posedge clk); #1;
    check("t1_done_pulse", 32'(burst_done_o), 32'd0);

    // 2: continuous requests over four buffers, gappy valid
    req_i = 2'b11; vmode = 1;
    do_reset();
    for (int b = 0; b < 4; b++) begin
      run_burst($sformatf("t2_b%0d", b), g, nb0, nb1, nh, oerr, 0);
      check($sformatf("t2_grant%0d", b), 32'(g), 32'(exp_seq[b]));
      check($sformatf("t2_own_beats%0d", b), 32'(g[0] ? nb0 : nb1), 32'(BL));
      check($sformatf("t2_other_beats%0d", b), 32'(g[0] ? nb1 : nb0), 32'd0);
    end
    vmode = 0;

    // 3: granted consumer toggles ready
    req_i = 2'b01; crmode = 1;
    do_reset();
    run_burst("t3", g, nb0, nb1, nh, oerr, 0);
    check("t3_grant", 32'(g), 32'd1);
    check("t3_beats", 32'(nb0), 32'(BL));
    check("t3_ram_hs", 32'(nh), 32'(BL));
    check("t3_order", 32'(oerr), 32'd0);
    crmode = 0;

    // 4: buffer ready but nobody asks; then consumer 1 asks and drops req
    req_i = 2'b00;
    do_reset();
    repeat (100) @(posedge clk);
    #1;
    check("t4_idle_ready", 32'(ram_ready_o), 32'd0);
    check("t4_idle_busy", 32'(busy_o), 32'd0);
    check("t4_idle_grant", 32'(grant_o), 32'd0);
    req_i = 2'b10;
    @(posedge clk); #1;
    check("t4_arb_grant", 32'(grant_o), 32'd0);
    @(posedge clk); #1;
    check("t4_grant", 32'(grant_o), 32'd2);
    req_i = 2'b00;
    run_burst("t4", g, nb0, nb1, nh, oerr, 0);
    check("t4_beats1", 32'(nb1), 32'(BL));
    check("t4_beats0", 32'(nb0), 32'd0);

    // 5: reset in the middle of consumer 1's burst sends pointer back to 0
    req_i = 2'b11;
    do_reset();
    run_burst("t5a", g, nb0, nb1, nh, oerr, 0);
    check("t5_first", 32'(g), 32'd1);
    run_burst("t5b", g, nb0, nb1, nh, oerr, 100);
    check("t5_second", 32'(g), 32'd2);
    check("t5_partial", 32'(nb1), 32'd100);
    @(posedge clk); #1;
    rst_ni = 1'b0;
    @(posedge clk); #1;
    check_all_zero("t5_abort");
    rst_ni = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("t5_regrant", 32'(grant_o), 32'd1);

`ifdef RAM_ARB_WDOG_EN
    // 6: consumer 0 stalls after 10 beats; watchdog drains the buffer
    req_i = 2'b11; crmode = 0;
    do_reset();
    n = 0; t = 0;
    @(negedge clk);
    while (n < 10 && t < 64) begin
      if (cons_valid_o[0] && cons_ready_i[0]) n++;
      if (n < 10) begin @(negedge clk); t++; end
    end
    if (n < 10) fail_now("t6_first_beats");
    check("t6_grant", 32'(grant_o), 32'd1);
    cr_hold = '0; crmode = 2;
    repeat (16) @(posedge clk);
    #1;
    check("t6_err_before", 32'(err_o), 32'd0);
    @(posedge clk); #1;
    check("t6_err_set", 32'(err_o), 32'd1);
    check("t6_drain_ready", 32'(ram_ready_o), 32'd1);
    check("t6_drain_valid", 32'(cons_valid_o), 32'd0);
    crmode = 0;
    nd = 0; t = 0;
    do begin
      @(negedge clk);
      if (ram_valid_i && ram_ready_o) nd++;
      t++;
    end while (!burst_done_o && t < 2000);
    if (!burst_done_o) fail_now("t6_drain_wait");
    check("t6_drained", 32'(nd), 32'd246);
    run_burst("t6", g, nb0, nb1, nh, oerr, 0);
    check("t6_next_grant", 32'(g), 32'd2);
    check("t6_next_beats", 32'(nb1), 32'(BL));
    check("t6_err_sticky", 32'(err_o), 32'd1);
`endif

    req_i = 2'b00;
    repeat (4) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ram_read_arbiter.md
Name: ram_read_arbiter

Overview:
- Shares the single ram_logic read stream (24-bit PCM, ready/valid) between N consumers, e.g. left VU meter, right VU meter and a spare analysis block.
- Grants the stream to one consumer for one whole buffer (a burst of BURST_LEN samples), using round-robin fairness.
- Forwards the handshake between ram_logic and the granted consumer only.
- Sits between ram_logic and the vu_meter_6led instances, which run in RAM-interface mode.

Parameters:
- N_CONS, 2: number of consumers (1..8).
- DATA_W, 24: sample width.
- BURST_LEN, 256: samples per grant. Equals the ram_logic buffer depth.
- WDOG_CYCLES, 4096: stall limit. Used only with RAM_ARB_WDOG_EN.

Ports:
- clk_i  in  1  system clock, 27 MHz.
- rst_ni  in  1  synchronous, active-low reset.
- buf_ready_i  in  1  ram_logic buffer_ready_o: a full buffer is available.
- ram_data_i  in  DATA_W  ram_logic read_data_o.
- ram_valid_i  in  1  ram_logic read_valid_o.
- ram_ready_o  out  1  to ram_logic read_ready_i.
- req_i  in  N_CONS  consumer request, level.
- cons_data_o  out  DATA_W  ram_data_i broadcast to all consumers.
- cons_valid_o  out  N_CONS  one-hot valid, active only on the granted consumer.
- cons_ready_i  in  N_CONS  consumer ready signals.
- grant_o  out  N_CONS  registered one-hot grant.
- busy_o  out  1  high in states ARB, XFER and DRAIN.
- burst_done_o  out  1  one-cycle pulse at the end of each burst.
- err_o  out  1  sticky watchdog error.

Behaviour:
- Clocking and reset: single clock. Reset is synchronous and active-low (rst_ni sampled on posedge clk_i).
- Reset values:
  - state = IDLE.
  - grant_o = 0, busy_o = 0, burst_done_o = 0, err_o = 0.
  - ram_ready_o = 0, cons_valid_o = 0.
  - beat counter = 0; round-robin pointer = 0, so consumer 0 has first priority.
- Reset mid-burst aborts immediately with no drain. ram_logic is reset by the same rst_ni.
- States: IDLE, ARB, XFER, DONE, and DRAIN (DRAIN exists only with RAM_ARB_WDOG_EN).
- IDLE:
  - Moves to ARB when buf_ready_i && |req_i.
  - buf_ready_i with no requests: stay in IDLE; ram_ready_o stays 0, so the data is held in RAM.
- ARB (1 cycle):
  - Selects the first requesting index at or after the pointer, wrapping modulo N_CONS.
  - Registers grant_o, clears the beat counter, then moves to XFER.
  - If req_i is all-zero in this cycle, return to IDLE with no grant.
- XFER: all outputs below are combinational from registered grant_o.
  - ram_ready_o = |(cons_ready_i & grant_o).
  - cons_valid_o = grant_o replicated AND ram_valid_i.
  - cons_data_o = ram_data_i, always.
  - Beat = ram_valid_i && ram_ready_o. Each beat increments the counter; width is $clog2(BURST_LEN+1).
  - On the beat with counter == BURST_LEN-1, move to DONE.
  - The grant is held for the whole burst even if the granted consumer drops its req_i. This guarantees ram_logic always drains a full buffer.
- DONE (1 cycle):
  - burst_done_o = 1 and grant_o cleared.
  - Pointer = granted index + 1, mod N_CONS.
  - Return to IDLE, so a new request can be granted 2 cycles after DONE at the earliest.
- Fairness: with all consumers requesting continuously, grants rotate 0,1,..,N-1,0.
- Latency: the first beat can happen 2 cycles after buf_ready_i&&req is seen (IDLE→ARB→XFER). Zero added latency on data (combinational pass-through).
- Ungranted consumers always see cons_valid_o = 0 and their cons_ready_i is ignored.

Optional Feature:
- Macro: RAM_ARB_WDOG_EN.
- Defined:
  - A stall counter clears on every beat and increments on each XFER cycle with no beat.
  - At WDOG_CYCLES, err_o latches to 1 (cleared only by reset) and the FSM enters DRAIN.
  - DRAIN: ram_ready_o = 1, cons_valid_o = 0, beats are counted and data discarded. On the final beat go to DONE; the pointer still advances past the stalled consumer.
- Not defined: no DRAIN state and no stall counter; err_o is tied to 0. A stalled consumer blocks the arbiter indefinitely.

Test Plan:
1. Reset with buf_ready_i=1, req_i=2'b11 held → all outputs 0 during reset. First grant_o=2'b01 two cycles after reset release; 256 beats forwarded, then one burst_done_o pulse.
2. Both requesting continuously over 4 buffers → grant sequence 01,10,01,10; exactly 256 cons_valid_o beats per grant, none on the other consumer.
3. Granted consumer toggles cons_ready_i 50% → ram_ready_o mirrors it exactly; byte-exact data order; burst still ends after exactly 256 beats.
4. buf_ready_i=1 with req_i=0 for 100 cycles → ram_ready_o=0 and state IDLE. Then req_i=2'b10 → grant_o=2'b10.
5. rst_ni low at beat 100 of a burst → next cycle all outputs 0; after release with both requesting, grant_o=2'b01 (pointer back at 0).
6. (RAM_ARB_WDOG_EN, WDOG_CYCLES=16) granted consumer holds cons_ready_i=0 after beat 10 → err_o=1 after 16 stall cycles; remaining 246 beats drained with ram_ready_o=1; next grant goes to the other consumer.
